// File: rtl/load_resp_pkg.sv
// Shared types for the load response buffer: access size encoding and per-entry state.
// Widths follow the core configuration (load-buffer depth, XLEN, scoreboard tag width).
package load_resp_pkg;

   localparam int unsigned CFG_LD_BUF_DEPTH  = 2;
   localparam int unsigned CFG_XLEN          = 32;
   localparam int unsigned CFG_TRANS_ID_BITS = 2;
   localparam int unsigned CFG_OFF_W         = $clog2(CFG_XLEN / 8);

   typedef enum logic [1:0] {
      BYTE  = 2'd0,
      HALF  = 2'd1,
      WORD  = 2'd2,
      DWORD = 2'd3
   } ld_size_e;

   typedef struct packed {
      logic                         valid;
      logic                         killed;
      logic [CFG_OFF_W-1:0]         offset;
      ld_size_e                     size;
      logic                         sign;
      logic [CFG_TRANS_ID_BITS-1:0] trans_id;
   } ld_entry_t;

endpackage

// File: rtl/load_data_extract.sv
// Load data extraction: shift the aligned word down by the byte offset, then sign/zero extend.
// Purely combinational; no state, no handshake.
module load_data_extract
   import load_resp_pkg::*;
#(
   parameter int unsigned XLEN  = CFG_XLEN,
   parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
   input  logic [OFF_W-1:0] offset,
   input  ld_size_e         size,
   input  logic             sign,
   input  logic [XLEN-1:0]  data,
   output logic [XLEN-1:0]  result
);

   logic [OFF_W+2:0] shamt;
   logic [XLEN-1:0]  shifted;

   assign shamt   = {offset, 3'b000};
   assign shifted = data >> shamt;

   // Misaligned half accesses simply take whatever the shift leaves in the low bits.
   always_comb begin
      result = shifted;
      case (size)
         BYTE:    result = {{(XLEN-8){sign & shifted[7]}}, shifted[7:0]};
         HALF:    result = {{(XLEN-16){sign & shifted[15]}}, shifted[15:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/load_resp_buffer.sv
// Outstanding-load tracker: allocates buffer IDs, matches cache responses, emits extracted writeback.
// Writeback 1 cycle after response, no backpressure; alloc_ready_o drops when full or flushing.
module load_resp_buffer
   import load_resp_pkg::*;
#(
   parameter int unsigned NR_ENTRIES    = CFG_LD_BUF_DEPTH,
   parameter int unsigned XLEN          = CFG_XLEN,
   parameter int unsigned TRANS_ID_BITS = CFG_TRANS_ID_BITS,
   parameter int unsigned ID_W          = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1,
   parameter int unsigned OFF_W         = $clog2(XLEN / 8)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     alloc_valid_i,
   output logic                     alloc_ready_o,
   output logic [ID_W-1:0]          alloc_id_o,
   input  logic [OFF_W-1:0]         alloc_offset_i,
   input  logic [1:0]               alloc_size_i,
   input  logic                     alloc_sign_i,
   input  logic [TRANS_ID_BITS-1:0] alloc_trans_id_i,
   input  logic                     resp_valid_i,
   input  logic [ID_W-1:0]          resp_id_i,
   input  logic [XLEN-1:0]          resp_data_i,
   output logic                     res_valid_o,
   output logic [TRANS_ID_BITS-1:0] res_trans_id_o,
   output logic [XLEN-1:0]          res_data_o,
   output logic [ID_W:0]            outstanding_o,
   output logic                     idle_o,
   output logic                     proto_err_o
);

   ld_entry_t        entries [NR_ENTRIES];
   ld_entry_t        sel;
   logic             any_free;
   logic [ID_W-1:0]  free_id;
   logic             alloc_fire;
   logic             resp_hit;
   logic             wb_fire;
   logic [XLEN-1:0]  ext_data;
   logic [ID_W:0]    count;

   // Lowest-index free entry wins: scan from the top so the last hit is the lowest.
   always_comb begin
      any_free = 1'b0;
      free_id  = '0;
      for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
         if (!entries[i].valid) begin
            any_free = 1'b1;
            free_id  = ID_W'(i);
         end
      end
   end

   always_comb begin
      sel   = '0;
      count = '0;
      for (int i = 0; i < NR_ENTRIES; i++) begin
         if (resp_id_i == ID_W'(i)) sel = entries[i];
         count = count + (ID_W+1)'(entries[i].valid);
      end
   end

   assign alloc_ready_o = any_free && !flush_i;
   assign alloc_id_o    = free_id;
   assign alloc_fire    = alloc_valid_i && alloc_ready_o;
   assign resp_hit      = resp_valid_i && sel.valid;
   assign wb_fire       = resp_hit && !sel.killed && !flush_i;
   assign outstanding_o = count;
   assign idle_o        = (count == '0);

   load_data_extract #(
      .XLEN  (XLEN),
      .OFF_W (OFF_W)
   ) u_extract (
      .offset (sel.offset),
      .size   (sel.size),
      .sign   (sel.sign),
      .data   (resp_data_i),
      .result (ext_data)
   );

   // Alloc never targets a valid entry and response only frees a valid one, so the
   // branches below never collide on the same entry; flush and alloc are exclusive.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NR_ENTRIES; i++) entries[i] <= '0;
         res_valid_o    <= 1'b0;
         res_trans_id_o <= '0;
         res_data_o     <= '0;
         proto_err_o    <= 1'b0;
      end else begin
         for (int i = 0; i < NR_ENTRIES; i++) begin
            if (resp_hit && resp_id_i == ID_W'(i)) begin
               entries[i] <= '0;
            end else if (alloc_fire && free_id == ID_W'(i)) begin
               entries[i].valid    <= 1'b1;
               entries[i].killed   <= 1'b0;
               entries[i].offset   <= alloc_offset_i;
               entries[i].size     <= ld_size_e'(alloc_size_i);
               entries[i].sign     <= alloc_sign_i;
               entries[i].trans_id <= alloc_trans_id_i;
            end else if (flush_i && entries[i].valid) begin
               entries[i].killed <= 1'b1;
            end
         end
         res_valid_o <= wb_fire;
         if (wb_fire) begin
            res_trans_id_o <= sel.trans_id;
            res_data_o     <= ext_data;
         end
         proto_err_o <= resp_valid_i && !resp_hit;
      end
   end

endmodule

// File: tb/tb_load_resp_buffer.sv
// Directed bench for load_resp_buffer with a writeback scoreboard queue.
module tb_load_resp_buffer;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        alloc_valid_i = 1'b0;
   logic        alloc_ready_o;
   logic [0:0]  alloc_id_o;
   logic [1:0]  alloc_offset_i = '0;
   logic [1:0]  alloc_size_i = '0;
   logic        alloc_sign_i = 1'b0;
   logic [1:0]  alloc_trans_id_i = '0;
   logic        resp_valid_i = 1'b0;
   logic [0:0]  resp_id_i = '0;
   logic [31:0] resp_data_i = '0;
   logic        res_valid_o;
   logic [1:0]  res_trans_id_o;
   logic [31:0] res_data_o;
   logic [1:0]  outstanding_o;
   logic        idle_o;
   logic        proto_err_o;

   typedef struct {
      logic [1:0]  tid;
      logic [31:0] data;
   } wb_t;

   wb_t  sb_q[$];
   logic exp_perr = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk_i = ~clk_i;

   load_resp_buffer dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .flush_i          (flush_i),
      .alloc_valid_i    (alloc_valid_i),
      .alloc_ready_o    (alloc_ready_o),
      .alloc_id_o       (alloc_id_o),
      .alloc_offset_i   (alloc_offset_i),
      .alloc_size_i     (alloc_size_i),
      .alloc_sign_i     (alloc_sign_i),
      .alloc_trans_id_i (alloc_trans_id_i),
      .resp_valid_i     (resp_valid_i),
      .resp_id_i        (resp_id_i),
      .resp_data_i      (resp_data_i),
      .res_valid_o      (res_valid_o),
      .res_trans_id_o   (res_trans_id_o),
      .res_data_o       (res_data_o),
      .outstanding_o    (outstanding_o),
      .idle_o           (idle_o),
      .proto_err_o      (proto_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then check writeback and protocol-error outputs against the model.
   task automatic tick();
      wb_t e;
      @(posedge clk_i);
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("wb_vld", {31'd0, res_valid_o}, 32'd1);
         chk("wb_tid", {30'd0, res_trans_id_o}, {30'd0, e.tid});
         chk("wb_dat", res_data_o, e.data);
      end else begin
         chk("no_wb", {31'd0, res_valid_o}, 32'd0);
      end
      chk("perr", {31'd0, proto_err_o}, {31'd0, exp_perr});
      exp_perr = 1'b0;
   endtask

   task automatic do_alloc(input logic [1:0] off, input logic [1:0] sz, input logic sg,
                           input logic [1:0] tid, input logic exp_id);
      alloc_valid_i    = 1'b1;
      alloc_offset_i   = off;
      alloc_size_i     = sz;
      alloc_sign_i     = sg;
      alloc_trans_id_i = tid;
      #1;
      chk("alloc_rdy", {31'd0, alloc_ready_o}, 32'd1);
      chk("alloc_id", {31'd0, alloc_id_o}, {31'd0, exp_id});
      tick();
      alloc_valid_i = 1'b0;
   endtask

   task automatic drive_resp(input logic id, input logic [31:0] data);
      resp_valid_i = 1'b1;
      resp_id_i    = id;
      resp_data_i  = data;
   endtask

   task automatic do_resp(input logic id, input logic [31:0] data, input logic wb,
                          input logic [1:0] tid, input logic [31:0] exp_data);
      drive_resp(id, data);
      if (wb) sb_q.push_back('{tid: tid, data: exp_data});
      tick();
      resp_valid_i = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_res_vld", {31'd0, res_valid_o}, 32'd0);
      chk("rst_res_tid", {30'd0, res_trans_id_o}, 32'd0);
      chk("rst_res_dat", res_data_o, 32'd0);
      chk("rst_perr", {31'd0, proto_err_o}, 32'd0);
      chk("rst_outst", {30'd0, outstanding_o}, 32'd0);
      chk("rst_idle", {31'd0, idle_o}, 32'd1);
      chk("rst_rdy", {31'd0, alloc_ready_o}, 32'd1);
      chk("rst_id", {31'd0, alloc_id_o}, 32'd0);
      rst_i = 1'b0;
      tick();

      // 1: signed byte at offset 1
      do_alloc(2'd1, 2'd0, 1'b1, 2'd3, 1'b0);
      chk("t1_outst", {30'd0, outstanding_o}, 32'd1);
      chk("t1_idle0", {31'd0, idle_o}, 32'd0);
      do_resp(1'b0, 32'h0000_8000, 1'b1, 2'd3, 32'hFFFF_FF80);
      chk("t1_idle1", {31'd0, idle_o}, 32'd1);
      tick();

      // 2: fill, full stays full during the response cycle
      do_alloc(2'd0, 2'd2, 1'b0, 2'd0, 1'b0);
      do_alloc(2'd0, 2'd2, 1'b0, 2'd1, 1'b1);
      chk("t2_full_rdy", {31'd0, alloc_ready_o}, 32'd0);
      chk("t2_outst2", {30'd0, outstanding_o}, 32'd2);
      drive_resp(1'b1, 32'h1111_2222);
      sb_q.push_back('{tid: 2'd1, data: 32'h1111_2222});
      #1;
      chk("t2_rdy_resp_cyc", {31'd0, alloc_ready_o}, 32'd0);
      tick();
      resp_valid_i = 1'b0;
      #1;
      chk("t2_rdy_next", {31'd0, alloc_ready_o}, 32'd1);
      chk("t2_id_next", {31'd0, alloc_id_o}, 32'd1);
      chk("t2_outst1", {30'd0, outstanding_o}, 32'd1);
      do_resp(1'b0, 32'h3333_4444, 1'b1, 2'd0, 32'h3333_4444);
      tick();

      // 3: flush kills both in-flight loads
      do_alloc(2'd0, 2'd2, 1'b0, 2'd2, 1'b0);
      do_alloc(2'd0, 2'd2, 1'b0, 2'd3, 1'b1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("t3_outst_after_flush", {30'd0, outstanding_o}, 32'd2);
      do_resp(1'b0, 32'hDEAD_0001, 1'b0, 2'd0, 32'd0);
      chk("t3_idle0", {31'd0, idle_o}, 32'd0);
      chk("t3_outst1", {30'd0, outstanding_o}, 32'd1);
      do_resp(1'b1, 32'hDEAD_0002, 1'b0, 2'd0, 32'd0);
      chk("t3_idle1", {31'd0, idle_o}, 32'd1);

      // 4: flush + live response + alloc request in one cycle
      do_alloc(2'd0, 2'd2, 1'b0, 2'd1, 1'b0);
      flush_i       = 1'b1;
      alloc_valid_i = 1'b1;
      drive_resp(1'b0, 32'hCAFE_F00D);
      #1;
      chk("t4_rdy_flush", {31'd0, alloc_ready_o}, 32'd0);
      tick();
      flush_i       = 1'b0;
      alloc_valid_i = 1'b0;
      resp_valid_i  = 1'b0;
      chk("t4_outst0", {30'd0, outstanding_o}, 32'd0);
      chk("t4_idle", {31'd0, idle_o}, 32'd1);

      // 5: response to a free entry
      do_alloc(2'd0, 2'd2, 1'b0, 2'd2, 1'b0);
      drive_resp(1'b1, 32'h5555_AAAA);
      exp_perr = 1'b1;
      tick();
      resp_valid_i = 1'b0;
      chk("t5_outst", {30'd0, outstanding_o}, 32'd1);
      tick();
      do_resp(1'b0, 32'h0BAD_BEEF, 1'b1, 2'd2, 32'h0BAD_BEEF);

      // 6: extraction variants, alloc + response on different IDs together
      do_alloc(2'd2, 2'd1, 1'b0, 2'd2, 1'b0);
      alloc_valid_i    = 1'b1;
      alloc_offset_i   = 2'd0;
      alloc_size_i     = 2'd2;
      alloc_sign_i     = 1'b0;
      alloc_trans_id_i = 2'd1;
      drive_resp(1'b0, 32'hBEEF_1234);
      sb_q.push_back('{tid: 2'd2, data: 32'h0000_BEEF});
      #1;
      chk("t6_alloc_id", {31'd0, alloc_id_o}, 32'd1);
      tick();
      alloc_valid_i = 1'b0;
      resp_valid_i  = 1'b0;
      chk("t6_outst_same", {30'd0, outstanding_o}, 32'd1);
      do_resp(1'b1, 32'hBEEF_1234, 1'b1, 2'd1, 32'hBEEF_1234);
      do_alloc(2'd2, 2'd1, 1'b1, 2'd0, 1'b0);
      do_resp(1'b0, 32'h8001_0000, 1'b1, 2'd0, 32'hFFFF_8001);
      do_alloc(2'd3, 2'd0, 1'b0, 2'd3, 1'b0);
      do_resp(1'b0, 32'hA500_0000, 1'b1, 2'd3, 32'h0000_00A5);
      chk("t6_idle", {31'd0, idle_o}, 32'd1);

      // Reset mid-operation discards entries; late response is a protocol error
      do_alloc(2'd0, 2'd2, 1'b0, 2'd1, 1'b0);
      rst_i = 1'b1;
      #1;
      chk("mr_outst", {30'd0, outstanding_o}, 32'd0);
      chk("mr_idle", {31'd0, idle_o}, 32'd1);
      tick();
      rst_i = 1'b0;
      drive_resp(1'b0, 32'h1234_5678);
      exp_perr = 1'b1;
      tick();
      resp_valid_i = 1'b0;
      tick();

      chk("sb_empty", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
